// File: rtl/buffer_resultados8.sv
// buffer_resultados8 -- first-word-fall-through result buffer placed after the
// 8-bit adder stage. Captures {RCO, Q} on IN_VALID, hands entries downstream
// over a valid/ready handshake, and reports occupancy plus a sticky overflow.
// Optional feature macro: BUFFER_RESULTADOS8_STATS_EN adds DROP_CNT/CARRY_CNT.
module buffer_resultados8 #(
   parameter int DEPTH = 4,
   parameter int CW    = 5
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IN_VALID,
   input  logic [7:0]    IN_Q,
   input  logic          IN_RCO,
   input  logic          OUT_READY,
   output logic          OUT_VALID,
   output logic [7:0]    OUT_Q,
   output logic          OUT_RCO,
   input  logic          CLR_OVF,
   output logic          FULL,
   output logic          EMPTY,
   output logic [CW-1:0] COUNT,
   output logic          OVERFLOW
`ifdef BUFFER_RESULTADOS8_STATS_EN
   ,
   output logic [7:0]    DROP_CNT,
   output logic [7:0]    CARRY_CNT
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [8:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          pop, push, reject;

`ifdef BUFFER_RESULTADOS8_STATS_EN
   logic [7:0] drop_q, drop_d;
   logic [7:0] carry_q, carry_d;

   // Saturating 8-bit increment; the counter sticks at 255
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction
`endif

   assign EMPTY     = (count_q == '0);
   assign FULL      = (count_q == CW'(DEPTH));
   assign COUNT     = count_q;
   assign OVERFLOW  = ovf_q;
   assign OUT_VALID = ~EMPTY;

   // Head entry is read combinationally and forced to zero while empty
   always_comb begin
      OUT_Q   = 8'h00;
      OUT_RCO = 1'b0;
      if (!EMPTY) begin
         OUT_Q   = mem_q[rd_ptr_q][7:0];
         OUT_RCO = mem_q[rd_ptr_q][8];
      end
   end

   // Handshake decode and next-state for pointers, occupancy and flags
   always_comb begin
      pop      = OUT_VALID & OUT_READY;
      push     = IN_VALID & (~FULL | pop);
      reject   = IN_VALID & FULL & ~pop;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      // A reject in the same cycle as a clear keeps the flag set
      if (reject)       ovf_d = 1'b1;
      else if (CLR_OVF) ovf_d = 1'b0;
   end

   // Control state: reset has priority over every other update
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage array is data only and is never reset; writes blocked during reset
   always_ff @(posedge CLK) begin
      if (push && !RST) mem_q[wr_ptr_q] <= {IN_RCO, IN_Q};
   end

`ifdef BUFFER_RESULTADOS8_STATS_EN
   // Statistics next-state: drops and carry-bearing accepted pushes
   always_comb begin
      drop_d  = drop_q;
      carry_d = carry_q;
      if (reject)          drop_d  = sat_inc8(drop_q);
      if (push && IN_RCO)  carry_d = sat_inc8(carry_q);
   end

   // Statistics registers, cleared only by reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         drop_q  <= 8'h00;
         carry_q <= 8'h00;
      end else begin
         drop_q  <= drop_d;
         carry_q <= carry_d;
      end
   end

   assign DROP_CNT  = drop_q;
   assign CARRY_CNT = carry_q;
`endif

endmodule

// File: tb/tb_buffer_resultados8.sv
// Self-checking bench for buffer_resultados8 using a queue scoreboard.
// Build with BUFFER_RESULTADOS8_STATS_EN defined to also exercise the counters.
module tb_buffer_resultados8;

   localparam int DEPTH = 4;
   localparam int CW    = 5;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_rco, out_ready, clr_ovf;
   logic [7:0]    in_q;
   logic          out_valid, out_rco, full, empty, overflow;
   logic [7:0]    out_q;
   logic [CW-1:0] count;
`ifdef BUFFER_RESULTADOS8_STATS_EN
   logic [7:0]    drop_cnt, carry_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [8:0] sb [$];
   bit         m_ovf;
   int         m_drops, m_carries;

   always #5 clk = ~clk;

   buffer_resultados8 #(.DEPTH(DEPTH), .CW(CW)) dut (
      .CLK       (clk),
      .RST       (rst),
      .IN_VALID  (in_valid),
      .IN_Q      (in_q),
      .IN_RCO    (in_rco),
      .OUT_READY (out_ready),
      .OUT_VALID (out_valid),
      .OUT_Q     (out_q),
      .OUT_RCO   (out_rco),
      .CLR_OVF   (clr_ovf),
      .FULL      (full),
      .EMPTY     (empty),
      .COUNT     (count),
      .OVERFLOW  (overflow)
`ifdef BUFFER_RESULTADOS8_STATS_EN
      ,
      .DROP_CNT  (drop_cnt),
      .CARRY_CNT (carry_cnt)
`endif
   );

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: check head at negedge, advance model at posedge, check flags after
   task automatic step();
      bit pop, push, rej;
      int sz;
      @(negedge clk);
      sz = sb.size();
      chk("out_valid", out_valid, (sz > 0) ? 1 : 0);
      if (sz > 0) chk("head", {out_rco, out_q}, sb[0]);
      else        chk("empty_data", {out_rco, out_q}, 0);
      pop  = (sz > 0) && out_ready;
      push = in_valid && ((sz < DEPTH) || pop);
      rej  = in_valid && (sz == DEPTH) && !pop;
      @(posedge clk);
      if (rst) begin
         sb.delete();
         m_ovf = 0; m_drops = 0; m_carries = 0;
      end else begin
         if (pop) void'(sb.pop_front());
         if (push) begin
            sb.push_back({in_rco, in_q});
            if (in_rco && m_carries < 255) m_carries++;
         end
         if (rej) begin
            m_ovf = 1;
            if (m_drops < 255) m_drops++;
         end else if (clr_ovf) m_ovf = 0;
      end
      #1;
      chk("count", count, sb.size());
      chk("full", full, (sb.size() == DEPTH) ? 1 : 0);
      chk("empty", empty, (sb.size() == 0) ? 1 : 0);
      chk("overflow", overflow, m_ovf);
`ifdef BUFFER_RESULTADOS8_STATS_EN
      chk("drop_cnt", drop_cnt, m_drops);
      chk("carry_cnt", carry_cnt, m_carries);
`endif
   endtask

   task automatic drive(input bit v, input bit c, input logic [7:0] q, input bit r);
      in_valid = v; in_rco = c; in_q = q; out_ready = r;
   endtask

   initial begin
      rst = 1; clr_ovf = 0;
      drive(1, 1, 8'h5A, 1);
      m_ovf = 0; m_drops = 0; m_carries = 0;
      @(posedge clk); #1;
      // Reset held a second cycle with IN_VALID high
      step();
      rst = 0;

      // Ordering
      drive(1, 0, 8'h11, 0); step();
      drive(1, 1, 8'h22, 0); step();
      drive(1, 0, 8'h33, 0); step();
      chk("order_count3", count, 3);
      drive(0, 0, 8'h00, 1);
      repeat (4) step();
      chk("order_empty", empty, 1);

      // Overflow: five pushes into four slots
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 8'hA0 + 8'(i), 0); step();
      end
      chk("ovf_full", full, 1);
      chk("ovf_set", overflow, 1);
      chk("ovf_head", out_q, 8'hA0);
      // Reject and clear together: set wins
      clr_ovf = 1; drive(1, 0, 8'hEE, 0); step();
      chk("ovf_set_wins", overflow, 1);
      drive(0, 0, 8'h00, 1); clr_ovf = 0;
      repeat (5) step();
      clr_ovf = 1; drive(0, 0, 8'h00, 0); step(); clr_ovf = 0;
      chk("ovf_cleared", overflow, 0);

      // Full plus simultaneous push and pop
      for (int i = 0; i < 4; i++) begin
         drive(1, i[0], 8'hB1 + 8'(i), 0); step();
      end
      drive(1, 1, 8'hB5, 1); step();
      chk("fullpp_count", count, 4);
      chk("fullpp_noovf", overflow, 0);
      drive(0, 0, 8'h00, 1);
      repeat (5) step();

      // Wrap-around: continuous push and pop
      for (int i = 0; i < 20; i++) begin
         drive(1, i[1], 8'(i), 1); step();
         chk("wrap_cnt_le1", (count <= 1) ? 1 : 0, 1);
      end
      drive(0, 0, 8'h00, 1); step();
      chk("wrap_noovf", overflow, 0);

      // Reset mid-operation
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 8'hC0 + 8'(i), 0); step();
      end
      chk("mid_count3", count, 3);
      rst = 1; drive(1, 1, 8'hCC, 1); step();
      rst = 0; drive(0, 0, 8'h00, 1);
      chk("mid_rst_empty", empty, 1);
      step();

`ifdef BUFFER_RESULTADOS8_STATS_EN
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 8'hD0 + 8'(i), 0); step();
      end
      for (int i = 0; i < 300; i++) begin
         drive(1, 0, 8'hDD, 0); step();
      end
      chk("drop_sat", drop_cnt, 255);
      chk("carry_val", carry_cnt, 4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
